// File: rtl/cfg_info_pkg.sv
// Register map, magic word, flag bit positions and FSM states for the
// configuration-info responder.
package cfg_info_pkg;

  localparam logic [31:0] MAGIC = 32'h4356_4136;  // "CVA6"

  localparam logic [31:0] OFF_MAGIC      = 32'h000;
  localparam logic [31:0] OFF_XLEN       = 32'h004;
  localparam logic [31:0] OFF_FLAGS      = 32'h008;
  localparam logic [31:0] OFF_COMMIT     = 32'h00C;
  localparam logic [31:0] OFF_SB         = 32'h010;
  localparam logic [31:0] OFF_ICACHE     = 32'h014;
  localparam logic [31:0] OFF_DCACHE     = 32'h018;
  localparam logic [31:0] OFF_ASSOC      = 32'h01C;
  localparam logic [31:0] OFF_PMP        = 32'h020;
  localparam logic [31:0] OFF_CNT        = 32'h024;
  localparam logic [31:0] OFF_NR_CACHED  = 32'h100;
  localparam logic [31:0] OFF_NR_EXEC    = 32'h104;
  localparam logic [31:0] OFF_NR_NONIDEM = 32'h108;
  localparam logic [31:0] OFF_RULE_BASE  = 32'h200;  // 16 rules x 16 bytes

  localparam int FLAG_RVA     = 0;
  localparam int FLAG_RVB     = 1;
  localparam int FLAG_RVC     = 2;
  localparam int FLAG_RVH     = 3;
  localparam int FLAG_RVV     = 4;
  localparam int FLAG_FPU     = 5;
  localparam int FLAG_RVZCB   = 6;
  localparam int FLAG_RVZCMP  = 7;
  localparam int FLAG_CVXIF   = 8;
  localparam int FLAG_RVS     = 9;
  localparam int FLAG_RVU     = 10;
  localparam int FLAG_MMU     = 11;
  localparam int FLAG_DEBUG   = 12;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_e;

endpackage

// File: rtl/config_pkg.sv
// Core configuration record type shared by CVA6 blocks; only the fields the
// configuration-info responder exposes to software are carried here.
package config_pkg;

  typedef struct packed {
    int unsigned       XLEN;
    bit                RVA;
    bit                RVB;
    bit                RVC;
    bit                RVH;
    bit                RVV;
    bit                FpuEn;
    bit                RVZCB;
    bit                RVZCMP;
    bit                CvxifEn;
    bit                RVS;
    bit                RVU;
    bit                MmuPresent;
    bit                DebugEn;
    int unsigned       NrCommitPorts;
    int unsigned       NrScoreboardEntries;
    int unsigned       IcacheByteSize;
    int unsigned       DcacheByteSize;
    int unsigned       IcacheSetAssoc;
    int unsigned       DcacheSetAssoc;
    int unsigned       NrPMPEntries;
    int unsigned       NrNonIdempotentRules;
    int unsigned       NrExecuteRegionRules;
    int unsigned       NrCachedRegionRules;
    logic [15:0][63:0] CachedRegionAddrBase;
    logic [15:0][63:0] CachedRegionLength;
  } cva6_cfg_t;

endpackage

// File: rtl/cva6_config_pkg.sv
// Default core configuration: a small 32-bit embedded core with one cached
// region at 0x8000_0000.
package cva6_config_pkg;

  localparam config_pkg::cva6_cfg_t cva6_cfg = '{
    XLEN:                 32,
    RVA:                  1'b0,
    RVB:                  1'b1,
    RVC:                  1'b1,
    RVH:                  1'b0,
    RVV:                  1'b0,
    FpuEn:                1'b0,
    RVZCB:                1'b1,
    RVZCMP:               1'b0,
    CvxifEn:              1'b1,
    RVS:                  1'b0,
    RVU:                  1'b0,
    MmuPresent:           1'b0,
    DebugEn:              1'b0,
    NrCommitPorts:        1,
    NrScoreboardEntries:  4,
    IcacheByteSize:       2048,
    DcacheByteSize:       32768,
    IcacheSetAssoc:       4,
    DcacheSetAssoc:       8,
    NrPMPEntries:         8,
    NrNonIdempotentRules: 2,
    NrExecuteRegionRules: 3,
    NrCachedRegionRules:  1,
    CachedRegionAddrBase: {{15{64'h0}}, 64'h0000_0000_8000_0000},
    CachedRegionLength:   {{15{64'h0}}, 64'h0000_0000_4000_0000}
  };

endpackage

// File: rtl/cfg_info_decode.sv
// Combinational address-to-data decode of the read-only configuration words.
// Region table (0x100.., 0x200..) only exists when CFG_INFO_REGIONS_EN is defined.
module cfg_info_decode
  import cfg_info_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg   = cva6_config_pkg::cva6_cfg,
  parameter int unsigned           AddrWidth = 12
) (
  input  logic [AddrWidth-1:0] addr,
  input  logic                 we,
  input  logic [31:0]          cnt,
  output logic [31:0]          rdata,
  output logic                 err
);

  logic [31:0] a;
  logic [31:0] word;
  logic [31:0] flags;
  logic        hit;

  assign a = 32'(addr);

  always_comb begin
    flags              = '0;
    flags[FLAG_RVA]    = CVA6Cfg.RVA;
    flags[FLAG_RVB]    = CVA6Cfg.RVB;
    flags[FLAG_RVC]    = CVA6Cfg.RVC;
    flags[FLAG_RVH]    = CVA6Cfg.RVH;
    flags[FLAG_RVV]    = CVA6Cfg.RVV;
    flags[FLAG_FPU]    = CVA6Cfg.FpuEn;
    flags[FLAG_RVZCB]  = CVA6Cfg.RVZCB;
    flags[FLAG_RVZCMP] = CVA6Cfg.RVZCMP;
    flags[FLAG_CVXIF]  = CVA6Cfg.CvxifEn;
    flags[FLAG_RVS]    = CVA6Cfg.RVS;
    flags[FLAG_RVU]    = CVA6Cfg.RVU;
    flags[FLAG_MMU]    = CVA6Cfg.MmuPresent;
    flags[FLAG_DEBUG]  = CVA6Cfg.DebugEn;
  end

  always_comb begin
    word = '0;
    hit  = 1'b1;
    case (a)
      OFF_MAGIC:      word = MAGIC;
      OFF_XLEN:       word = 32'(CVA6Cfg.XLEN);
      OFF_FLAGS:      word = flags;
      OFF_COMMIT:     word = 32'(CVA6Cfg.NrCommitPorts);
      OFF_SB:         word = 32'(CVA6Cfg.NrScoreboardEntries);
      OFF_ICACHE:     word = 32'(CVA6Cfg.IcacheByteSize);
      OFF_DCACHE:     word = 32'(CVA6Cfg.DcacheByteSize);
      OFF_ASSOC:      word = {16'(CVA6Cfg.DcacheSetAssoc), 16'(CVA6Cfg.IcacheSetAssoc)};
      OFF_PMP:        word = 32'(CVA6Cfg.NrPMPEntries);
      OFF_CNT:        word = cnt;
`ifdef CFG_INFO_REGIONS_EN
      OFF_NR_CACHED:  word = 32'(CVA6Cfg.NrCachedRegionRules);
      OFF_NR_EXEC:    word = 32'(CVA6Cfg.NrExecuteRegionRules);
      OFF_NR_NONIDEM: word = 32'(CVA6Cfg.NrNonIdempotentRules);
`endif
      default: begin
`ifdef CFG_INFO_REGIONS_EN
        // a[7:4] selects the rule, a[3:2] the half-word of base/length
        if ((a & ~32'h0FF) == OFF_RULE_BASE) begin
          if (32'(a[7:4]) < CVA6Cfg.NrCachedRegionRules) begin
            case (a[3:2])
              2'd0:    word = CVA6Cfg.CachedRegionAddrBase[a[7:4]][31:0];
              2'd1:    word = CVA6Cfg.CachedRegionAddrBase[a[7:4]][63:32];
              2'd2:    word = CVA6Cfg.CachedRegionLength[a[7:4]][31:0];
              default: word = CVA6Cfg.CachedRegionLength[a[7:4]][63:32];
            endcase
          end
        end else begin
          hit = 1'b0;
        end
`else
        hit = 1'b0;
`endif
      end
    endcase
  end

  assign err   = we || (a[1:0] != 2'b00) || !hit;
  assign rdata = err ? 32'h0 : word;

endmodule

// File: rtl/cfg_info_responder.sv
// Read-only configuration-info slave: valid/ready request, one registered
// response slot, read counter. Region table enabled by CFG_INFO_REGIONS_EN.
module cfg_info_responder
  import cfg_info_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg   = cva6_config_pkg::cva6_cfg,
  parameter int unsigned           AddrWidth = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_we_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_err_o
);

  state_e      state, state_nxt;
  logic        accept;
  logic [31:0] cnt;
  logic [31:0] dec_rdata;
  logic        dec_err;

  // The response slot frees up in the same cycle it is consumed.
  assign rsp_valid_o = (state == S_RESP);
  assign req_ready_o = !rsp_valid_o || rsp_ready_i;
  assign accept      = req_valid_i && req_ready_o;

  cfg_info_decode #(
    .CVA6Cfg   (CVA6Cfg),
    .AddrWidth (AddrWidth)
  ) u_decode (
    .addr  (req_addr_i),
    .we    (req_we_i),
    .cnt   (cnt),
    .rdata (dec_rdata),
    .err   (dec_err)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready_i && !accept) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      cnt         <= '0;
    end else if (accept) begin
      rsp_rdata_o <= dec_rdata;
      rsp_err_o   <= dec_err;
      if (!dec_err) cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_cfg_info_responder.sv
// Bench for cfg_info_responder: directed literal checks plus randomized traffic
// compared every cycle against a register-map model. Honours CFG_INFO_REGIONS_EN.
module tb_cfg_info_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [11:0] req_addr = '0;
  logic        rsp_ready = 1'b1;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cfg_info_responder dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_we_i    (req_we),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Software-visible register map of the default configuration.
  function automatic void ref_read(input logic [11:0] addr, input logic we,
                                   input logic [31:0] c,
                                   output logic [31:0] d, output logic e);
    int unsigned ai = addr;
    int unsigned rule, w;
    d = 0;
    e = 0;
    if (we || (ai % 4) != 0) begin
      e = 1;
      return;
    end
    if (ai < 'h100) begin
      case (ai)
        'h000: d = 32'h43564136;
        'h004: d = 32;
        'h008: d = 32'h146;
        'h00C: d = 1;
        'h010: d = 4;
        'h014: d = 2048;
        'h018: d = 32768;
        'h01C: d = (8 << 16) | 4;
        'h020: d = 8;
        'h024: d = c;
        default: e = 1;
      endcase
    end else begin
`ifdef CFG_INFO_REGIONS_EN
      if (ai == 'h100) d = 1;
      else if (ai == 'h104) d = 3;
      else if (ai == 'h108) d = 2;
      else if (ai >= 'h200 && ai < 'h300) begin
        rule = (ai - 'h200) / 16;
        w    = (ai % 16) / 4;
        if (rule == 0) d = (w == 0) ? 32'h8000_0000 : (w == 2) ? 32'h4000_0000 : 32'h0;
      end else e = 1;
`else
      e = 1;
`endif
    end
  endfunction

  // Model state: one response slot plus the read counter.
  logic        m_valid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;
  logic [31:0] m_cnt = '0;

  always @(negedge clk) begin
    logic [31:0] d;
    logic        e;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_rdata = '0;
      m_err   = 1'b0;
      m_cnt   = '0;
    end else begin
      check("mdl req_ready", 32'(req_ready), 32'(!m_valid || rsp_ready));
      check("mdl rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid) begin
        check("mdl rdata", rsp_rdata, m_rdata);
        check("mdl err", 32'(rsp_err), 32'(m_err));
      end
      if (req_valid && (!m_valid || rsp_ready)) begin
        ref_read(req_addr, req_we, m_cnt, d, e);
        m_valid = 1'b1;
        m_rdata = d;
        m_err   = e;
        if (!e) m_cnt = m_cnt + 32'd1;
      end else if (m_valid && rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic we, input logic [31:0] exp_d,
                    input logic exp_e, input string nm);
    req_valid = 1'b1;
    req_addr  = a;
    req_we    = we;
    step();
    req_valid = 1'b0;
    req_we    = 1'b0;
    check({nm, " valid"}, 32'(rsp_valid), 32'd1);
    check({nm, " rdata"}, rsp_rdata, exp_d);
    check({nm, " err"}, 32'(rsp_err), 32'(exp_e));
  endtask

  logic [11:0] alist [22] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014,
                              12'h018, 12'h01C, 12'h020, 12'h024, 12'h006, 12'h028,
                              12'h0FC, 12'h100, 12'h104, 12'h108, 12'h200, 12'h204,
                              12'h20C, 12'h210, 12'h2FC, 12'h300};

  initial begin
    repeat (3) step();
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rdata", rsp_rdata, 32'd0);
    check("reset err", 32'(rsp_err), 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // back-to-back counter reads
    req_valid = 1'b1;
    req_addr  = 12'h024;
    for (int k = 0; k < 3; k++) begin
      step();
      check("b2b cnt rdata", rsp_rdata, 32'(k));
      check("b2b req_ready", 32'(req_ready), 32'd1);
    end
    req_valid = 1'b0;

    rd(12'h000, 1'b0, 32'h43564136, 1'b0, "magic");
    rd(12'h008, 1'b0, 32'h00000146, 1'b0, "flags");
    rd(12'h004, 1'b1, 32'h0, 1'b1, "write");
    rd(12'h006, 1'b0, 32'h0, 1'b1, "misaligned");
    rd(12'h300, 1'b0, 32'h0, 1'b1, "unmapped");
    rd(12'h024, 1'b0, 32'd5, 1'b0, "cnt after errors");

    // backpressure: response must hold while rsp_ready is low
    step();
    rsp_ready = 1'b0;
    rd(12'h014, 1'b0, 32'h800, 1'b0, "icache");
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall rdata", rsp_rdata, 32'h800);
      check("stall req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check("release req_ready", 32'(req_ready), 32'd1);
    step();
    check("after handshake valid", 32'(rsp_valid), 32'd0);

`ifdef CFG_INFO_REGIONS_EN
    rd(12'h200, 1'b0, 32'h8000_0000, 1'b0, "rule0 base");
    rd(12'h210, 1'b0, 32'h0, 1'b0, "rule1 empty");
    rd(12'h100, 1'b0, 32'd1, 1'b0, "nr cached");
`else
    rd(12'h200, 1'b0, 32'h0, 1'b1, "no regions");
`endif

    // reset while a response is pending
    step();
    rsp_ready = 1'b0;
    rd(12'h000, 1'b0, 32'h43564136, 1'b0, "pre-reset");
    rst_n = 1'b0;
    #1;
    check("async reset valid", 32'(rsp_valid), 32'd0);
    check("async reset rdata", rsp_rdata, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    step();
    step();
    check("post-reset valid", 32'(rsp_valid), 32'd0);
    rd(12'h024, 1'b0, 32'd0, 1'b0, "cnt after reset");

    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = ($urandom_range(0, 9) == 0);
      req_addr  = ($urandom_range(0, 4) == 0) ? 12'($urandom) : alist[$urandom_range(0, 21)];
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cfg_info_responder.md
CFG_INFO_RESPONDER -- requirements
Module: cfg_info_responder

Interface
REQ-001 SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_t derived from cva6_config_pkg::cva6_cfg, giving the core configuration exposed to software.
REQ-002 SHALL have parameter AddrWidth, default 12, giving the request byte-address width.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid_i, input, 1, request valid.
REQ-006 SHALL have port req_ready_o, output, 1, request ready.
REQ-007 SHALL have port req_addr_i, input, AddrWidth, byte address.
REQ-008 SHALL have port req_we_i, input, 1, write flag; writes are illegal.
REQ-009 SHALL have port rsp_valid_o, output, 1, response valid.
REQ-010 SHALL have port rsp_ready_i, input, 1, response ready.
REQ-011 SHALL have port rsp_rdata_o, output, 32, read data.
REQ-012 SHALL have port rsp_err_o, output, 1, error flag for the response.

Function
REQ-013 SHALL accept a request when req_valid_i and req_ready_o are both high.
REQ-014 SHALL drive req_ready_o as (!rsp_valid_o || rsp_ready_i), allowing one outstanding response and back-to-back throughput of one per cycle.
REQ-015 SHALL assert rsp_valid_o in the cycle after acceptance, with rsp_rdata_o and rsp_err_o registered.
REQ-016 SHALL hold rsp_valid_o, rsp_rdata_o and rsp_err_o stable until rsp_ready_i is high.
REQ-017 SHALL implement a two-state FSM: IDLE goes to RESP on accept; RESP stays in RESP on a handshake coinciding with a new accept; RESP returns to IDLE on a handshake without a new accept.
REQ-018 SHALL decode 32-bit read-only words:
- 0x000 magic 0x43564136
- 0x004 XLEN
- 0x008 flags: b0 RVA, b1 RVB, b2 RVC, b3 RVH, b4 RVV, b5 FpuEn, b6 RVZCB, b7 RVZCMP, b8 CvxifEn, b9 RVS, b10 RVU, b11 MmuPresent, b12 DebugEn; others 0
- 0x00C NrCommitPorts
- 0x010 NrScoreboardEntries
- 0x014 IcacheByteSize
- 0x018 DcacheByteSize
- 0x01C {DcacheSetAssoc[15:0], IcacheSetAssoc[15:0]}
- 0x020 NrPMPEntries
- 0x024 read counter
REQ-019 SHALL keep a 32-bit read counter that increments by 1 per accepted non-error read, wrapping from 0xFFFFFFFF to 0.
REQ-020 SHALL return the counter value held before the increment when reading 0x024, and SHALL count that read.
REQ-021 SHALL respond with rsp_err_o=1 and rdata 0 to a write, to an address with addr[1:0]!=0, or to an unmapped address, and SHALL leave the counter unchanged.
REQ-022 SHALL zero-extend or truncate parameter values to 32 bits.

Reset
REQ-023 SHALL reset asynchronously on rst_ni low to: FSM IDLE, rsp_valid_o 0, rsp_rdata_o 0, rsp_err_o 0, counter 0; req_ready_o then reads 1.
REQ-024 SHALL drop any pending response when reset asserts mid-transaction, with no response after release.

Configuration
REQ-025 SHALL gate the region table with macro CFG_INFO_REGIONS_EN.
REQ-026 With the macro defined, SHALL map:
- 0x100 NrCachedRegionRules
- 0x104 NrExecuteRegionRules
- 0x108 NrNonIdempotentRules
- 0x200+16*i, i 0..15, cached rule i: base lo, base hi, length lo, length hi
- indices at or above the rule count read 0 without error
REQ-027 Without the macro, SHALL treat all addresses at or above 0x100 as unmapped (error response).

Structure
REQ-028 SHALL place the register offset localparams, the magic constant, the flag bit positions and the FSM state enum in shared package cfg_info_pkg.
REQ-029 SHALL implement address-to-data decode in one combinational sub-module, cfg_info_decode, and keep the handshake, FSM and counter in the top module.

Verification
REQ-030 Read 0x000 with rsp_ready_i=1 -> response next cycle, rdata 0x43564136, err 0.
REQ-031 Read 0x008 with the default config -> rdata 0x00000146 (RVB, RVC, RVZCB, CvxifEn set).
REQ-032 Three back-to-back reads of 0x024, rsp_ready_i=1 -> rdata 0, 1, 2 on consecutive cycles, req_ready_o held high.
REQ-033 Write 0x004, then read 0x006, then read 0x300 -> each err 1, rdata 0; a following read of 0x024 returns an unchanged count.
REQ-034 Accept read 0x014, hold rsp_ready_i=0 for 5 cycles -> rsp stays 0x800, req_ready_o 0; release -> handshake and req_ready_o 1.
REQ-035 Read 0x200 with the macro -> 0x80000000; read 0x210 -> 0 with err 0; without the macro, read 0x200 -> err 1; assert rst_ni mid-response -> rsp_valid_o 0 immediately.
